// File: rtl/cle_serial_sequencer.sv
// rtl/cle_serial_sequencer.sv - two-requester round-robin serial register sequencer
module cle_serial_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            rw,
    input  logic [5:0]            addr0,
    input  logic [5:0]            addr1,
    input  logic [FRAME_BITS-1:0] wdata0,
    input  logic [FRAME_BITS-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [FRAME_BITS-1:0] rdata,
    output logic                  busy,
    output logic                  sser_n,
    output logic [5:0]            ba,
    output logic                  br_w,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int              CW       = $clog2(FRAME_BITS + 1);
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BITS     = CW'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state_q;
    logic [1:0]            gnt_q, done_q;
    logic [FRAME_BITS-1:0] rdata_q, tx_q, rx_q;
    logic                  busy_q, sser_n_q, br_w_q, sck_q, sdo_q;
    logic [5:0]            ba_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [7:0]            div_q;
    logic                  last_q;
    logic                  armed_q;

    logic                  pick_d;
    logic                  grant_ok_d;
    logic                  div_wrap_d;
    logic [CW-1:0]         bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_load_d, tx_shift_d, rx_shift_d;

    always_comb begin
        pick_d = 1'b0;
        if (req == 2'b11) begin
            pick_d = ~last_q;
        end else if (req == 2'b10) begin
            pick_d = 1'b1;
        end
        // Holding off while done is high guarantees an IDLE cycle between transfers.
        grant_ok_d = (req != 2'b00) && (done_q == 2'b00) && armed_q;
        div_wrap_d = (div_q == DIV_LAST);
        bit_cnt_d  = bit_cnt_q + 1'b1;
        tx_load_d  = rw[pick_d] ? '0 : (pick_d ? wdata1 : wdata0);
        tx_shift_d = tx_q << 1;
        rx_shift_d = (rx_q << 1) | FRAME_BITS'(sdi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            sser_n_q  <= 1'b1;
            br_w_q    <= 1'b1;
            sck_q     <= 1'b0;
            sdo_q     <= 1'b0;
            ba_q      <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            last_q    <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (grant_ok_d) begin
                        state_q   <= SETUP;
                        gnt_q     <= pick_d ? 2'b10 : 2'b01;
                        last_q    <= pick_d;
                        busy_q    <= 1'b1;
                        sser_n_q  <= 1'b0;
                        ba_q      <= pick_d ? addr1 : addr0;
                        br_w_q    <= rw[pick_d];
                        sdo_q     <= tx_load_d[FRAME_BITS-1];
                        tx_q      <= tx_load_d << 1;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                SETUP: begin
                    if (div_wrap_d) begin
                        div_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_wrap_d) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            rx_q  <= rx_shift_d;
                        end else begin
                            // Falling sck completes a bit; the next bit is presented here.
                            sck_q     <= 1'b0;
                            bit_cnt_q <= bit_cnt_d;
                            if (bit_cnt_d == BITS) begin
                                state_q <= HOLD;
                                sdo_q   <= 1'b0;
                            end else begin
                                sdo_q <= tx_q[FRAME_BITS-1];
                                tx_q  <= tx_shift_d;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!div_wrap_d) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q    <= '0;
                        state_q  <= IDLE;
                        done_q   <= gnt_q;
                        gnt_q    <= 2'b00;
                        busy_q   <= 1'b0;
                        sser_n_q <= 1'b1;
                        if (br_w_q) begin
                            rdata_q <= rx_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign sser_n = sser_n_q;
    assign ba     = ba_q;
    assign br_w   = br_w_q;
    assign sck    = sck_q;
    assign sdo    = sdo_q;

endmodule

// File: tb/tb_cle_serial_sequencer.sv
// tb/tb_cle_serial_sequencer.sv - scoreboard bench for cle_serial_sequencer
module tb_cle_serial_sequencer;

    localparam int D = 4;
    localparam int F = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, rw;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata;
    logic       busy, sser_n, br_w, sck, sdo, sdi;
    logic [5:0] ba;

    logic [1:0] b_req, b_rw, b_gnt, b_done;
    logic [5:0] b_ba;
    logic [0:0] b_wdata0, b_wdata1, b_rdata;
    logic       b_busy, b_sser_n, b_br_w, b_sck, b_sdo, b_sdi;

    always #5 clk = ~clk;

    cle_serial_sequencer #(.CLK_DIV(D), .FRAME_BITS(F)) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .rdata(rdata),
        .busy(busy), .sser_n(sser_n), .ba(ba), .br_w(br_w), .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    cle_serial_sequencer #(.CLK_DIV(2), .FRAME_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .rw(b_rw), .addr0(6'h2A), .addr1(6'h01),
        .wdata0(b_wdata0), .wdata1(b_wdata1), .gnt(b_gnt), .done(b_done), .rdata(b_rdata),
        .busy(b_busy), .sser_n(b_sser_n), .ba(b_ba), .br_w(b_br_w), .sck(b_sck), .sdo(b_sdo), .sdi(b_sdi)
    );

    typedef struct {
        int         idx;
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] dev;
    } txn_t;

    txn_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] dev_val[2];
    bit         rr_last = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial device model: presents dev_val of the granted requester MSB first.
    int   dev_k;
    logic dev_prev_sck;
    always @(negedge clk) begin
        if (sser_n) begin
            dev_k = 0;
            dev_prev_sck = 1'b0;
        end else begin
            if (sck && !dev_prev_sck) dev_k++;
            dev_prev_sck = sck;
        end
        if (dev_k < F) sdi = gnt[1] ? dev_val[1][F-1-dev_k] : dev_val[0][F-1-dev_k];
        else sdi = 1'b0;
    end

    int         cyc = 0;
    int         t0, rises;
    int         last_done_cyc = -1000;
    bit         in_xfer = 0, expect_gap = 0;
    bit         rd_sdo_seen, unstable, sdo_hi_chg;
    logic [1:0] cap_gnt;
    logic [5:0] cap_ba;
    logic       cap_brw, prev_sck, prev_sdo;
    logic [7:0] sdo_bits, last_rd = 8'h00;
    txn_t       mon_e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_xfer    = 0;
            expect_gap = 0;
            last_rd    = 8'h00;
            prev_sck   = 1'b0;
        end else begin
            if (!in_xfer && !sser_n) begin
                in_xfer = 1;
                t0 = cyc;
                cap_gnt = gnt; cap_ba = ba; cap_brw = br_w;
                rises = 0; sdo_bits = 8'h00;
                rd_sdo_seen = 0; unstable = 0; sdo_hi_chg = 0;
                chk("gnt_onehot", $countones(gnt), 1);
                chk("busy_in_xfer", busy, 1);
                if (expect_gap) chk("idle_gap_exact", cyc - last_done_cyc, 2);
                else chk("idle_gap_min", (cyc - last_done_cyc) >= 2, 1);
                expect_gap = 0;
            end else if (in_xfer && !sser_n) begin
                if (sck && !prev_sck) begin
                    rises++;
                    sdo_bits = {sdo_bits[6:0], sdo};
                end
                if (sck && prev_sck && sdo != prev_sdo) sdo_hi_chg = 1;
                if (gnt != cap_gnt || ba != cap_ba || br_w != cap_brw || !busy) unstable = 1;
                if (cap_brw && sdo) rd_sdo_seen = 1;
            end
            if (done != 2'b00) begin
                if (!in_xfer) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    in_xfer = 0;
                    chk("done_vs_gnt", done, cap_gnt);
                    chk("xfer_len", cyc - t0, D * (2 * F + 2));
                    chk("sck_pulses", rises, F);
                    chk("sser_n_at_done", sser_n, 1);
                    chk("gnt_clear_at_done", gnt, 0);
                    chk("busy_at_done", busy, 0);
                    chk("held_stable", unstable, 0);
                    chk("sdo_stable_sck_high", sdo_hi_chg, 0);
                    if (sb.size() == 0) begin
                        chk("sb_underflow", sb.size(), 1);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("grant_order", cap_gnt, (mon_e.idx == 1) ? 2 : 1);
                        chk("ba", cap_ba, mon_e.addr);
                        chk("br_w", cap_brw, mon_e.rw);
                        if (mon_e.rw) begin
                            chk("read_sdo_zero", rd_sdo_seen, 0);
                            last_rd = mon_e.dev;
                        end else begin
                            chk("sdo_bits", sdo_bits, mon_e.wdata);
                        end
                        chk("rdata", rdata, last_rd);
                    end
                    expect_gap = (req & ~done) != 2'b00;
                    last_done_cyc = cyc;
                end
            end
            prev_sck = sck;
            prev_sdo = sdo;
        end
    end

    task automatic set_fields(input int i, input logic r, input logic [5:0] a,
                              input logic [7:0] w, input logic [7:0] dv);
        rw[i] = r;
        dev_val[i] = dv;
        if (i == 0) begin addr0 = a; wdata0 = w; end
        else begin addr1 = a; wdata1 = w; end
    endtask

    task automatic push_exp(input int i);
        txn_t t;
        t.idx = i; t.rw = rw[i];
        t.addr = (i == 1) ? addr1 : addr0;
        t.wdata = (i == 1) ? wdata1 : wdata0;
        t.dev = dev_val[i];
        sb.push_back(t);
        rr_last = (i == 1);
    endtask

    task automatic push_pattern(input logic [1:0] pat);
        int f;
        if (pat == 2'b11) begin
            f = rr_last ? 0 : 1;
            push_exp(f);
            push_exp(1 - f);
        end else begin
            push_exp(pat[1] ? 1 : 0);
        end
    endtask

    task automatic wait_done(input logic [1:0] pat, input bit drop);
        logic [1:0] remaining = pat;
        int budget = 2000;
        while (remaining != 2'b00 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
            remaining = remaining & ~done;
            req = req & ~done;
            if (drop && gnt != 2'b00 && sck) req = req & ~gnt;
        end
        if (budget == 0) chk("done_timeout", remaining, 0);
        req = 2'b00;
    endtask

    task automatic issue(input logic [1:0] pat, input bit drop);
        for (int i = 0; i < 2; i++)
            if (pat[i]) set_fields(i, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom));
        push_pattern(pat);
        req = pat;
        wait_done(pat, drop);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sser_n"}, sser_n, 1);
        chk({tag, "_sck"}, sck, 0);
        chk({tag, "_sdo"}, sdo, 0);
        chk({tag, "_br_w"}, br_w, 1);
        chk({tag, "_ba"}, ba, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic run_b(input logic rwv, input logic bitv);
        int t, len, pulses;
        logic prev, sdo_at;
        b_rw = {1'b0, rwv}; b_wdata0 = bitv; b_sdi = bitv; b_req = 2'b01;
        t = 0;
        while (b_sser_n && t < 50) begin @(negedge clk); t++; end
        len = 0; pulses = 0; prev = 1'b0; sdo_at = 1'b0;
        while (b_done == 2'b00 && len < 100) begin
            @(negedge clk);
            len++;
            if (b_sck && !prev) begin
                pulses++;
                sdo_at = b_sdo;
                b_req = 2'b00;
            end
            prev = b_sck;
        end
        chk("b_len", len, 8);
        chk("b_pulses", pulses, 1);
        chk("b_done", b_done, 2'b01);
        if (rwv) chk("b_rdata", b_rdata, bitv);
        else chk("b_sdo", sdo_at, bitv);
        b_req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r4, budget;
        logic p;
        rst = 1'b1; req = 2'b00; rw = 2'b00;
        addr0 = 6'h0; addr1 = 6'h0; wdata0 = 8'h0; wdata1 = 8'h0;
        dev_val[0] = 8'h00; dev_val[1] = 8'h00;
        b_req = 2'b00; b_rw = 2'b00; b_wdata0 = 1'b0; b_wdata1 = 1'b0; b_sdi = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");

        set_fields(0, 1'b0, 6'h15, 8'hA5, 8'h00);
        push_pattern(2'b01);
        req = 2'b01;
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("first_edge_no_grant", sser_n, 1);
        wait_done(2'b01, 1'b0);
        @(negedge clk); #1;

        set_fields(1, 1'b1, 6'h2B, 8'h00, 8'h3C);
        push_pattern(2'b10);
        req = 2'b10;
        wait_done(2'b10, 1'b0);

        for (int k = 0; k < 2; k++) issue(2'b11, 1'b0);
        for (int k = 0; k < 20; k++) issue(2'($urandom_range(1, 3)), 1'($urandom));

        set_fields(0, 1'b0, 6'($urandom), 8'($urandom), 8'h00);
        push_pattern(2'b01);
        req = 2'b01;
        r4 = 0; p = 1'b0; budget = 500;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (sck && !p) r4++;
            p = sck;
            if (r4 == 4 && sck) break;
        end
        chk("abort_reached_4th_high", r4, 4);
        #1 rst = 1'b1;
        #1 chk_reset("abort");
        sb.delete();
        rr_last = 1'b1;
        req = 2'b00;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        #1 rst = 1'b0;
        issue(2'b01, 1'b0);

        run_b(1'b0, 1'b1);
        run_b(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
